sine_voice_scheduler: RTL and testbench
=======================================

// Module: sine_voice_scheduler
// PURPOSE
//  Time-multiplexes the single 256x16 synchronous sine ROM among NUM_VOICES DDS voices.
//  On each sample_tick it sweeps all voices round-robin:
//   - issues each voice's phase (top 8 bits) as the ROM address;
//   - advances that voice's phase accumulator;
//   - returns each ROM word as a signed sample and, optionally, their sum.
//  Sits between the theremin pitch/frequency logic (FTW per voice) and the audio DAC path.
// PARAMETERS
//  NUM_VOICES  4   voices swept per sample_tick (>=1)
//  PHASE_W     24  phase accumulator / FTW width (>=8); ROM address = phase[PHASE_W-1 -: 8]
//  IDX_W       2   voice index width, >= clog2(NUM_VOICES), min 1
// PORTS
//  clock         in   1                     system clock, all logic on posedge
//  reset_n       in   1                     asynchronous active-low reset
//  sample_tick   in   1                     1-cycle strobe starting a sweep
//  ftw           in   NUM_VOICES*PHASE_W    packed tuning words, voice k at [k*PHASE_W +: PHASE_W]
//  voice_en      in   NUM_VOICES            per-voice enable
//  rom_addr      out  8                     registered address to sine ROM
//  rom_data      in   16                    ROM word, offset binary (0x7fff = zero)
//  voice_sample  out  16                    signed sample = rom_data ^ 16'h8000, registered
//  voice_idx     out  IDX_W                 voice index of voice_sample
//  voice_valid   out  1                     voice_sample/voice_idx valid this cycle
//  mix_out       out  16+IDX_W              signed sum of all voice samples for the sweep
//  mix_valid     out  1                     1-cycle strobe, mix_out valid
//  busy          out  1                     sweep in progress
//  overrun       out  1                     1-cycle pulse: sample_tick seen while busy
// BEHAVIOUR
//  - Reset (async, reset_n=0): state IDLE; all phase accumulators 0.
//    rom_addr, voice_sample, voice_idx, mix_out = 0; voice_valid, mix_valid, busy, overrun = 0.
//  - Reset asserted mid-sweep aborts the sweep; no further valid pulses are emitted.
//  - FSM states IDLE, ISSUE, DRAIN.
//    - IDLE: sample_tick=1 at edge E0 -> rom_addr <= phase[0] top bits, busy <= 1, go to ISSUE.
//    - ISSUE: issues voice k address at edge E0+k, k=1..NUM_VOICES-1. After the last issue, go to DRAIN.
//    - DRAIN: wait for the last ROM word, then return to IDLE.
//  - Voice k address issued at edge E0+k; at that same edge phase[k] <= phase[k] + ftw[k], mod 2^PHASE_W.
//    The first sweep after reset therefore reads address 0 for every voice.
//  - ROM latency is one edge:
//    - ROM registers its output at E0+k+1;
//    - voice_sample/voice_idx=k registered at E0+k+2;
//    - voice_valid high for the one cycle after E0+k+2;
//    - voices are delivered in order 0..NUM_VOICES-1 on consecutive cycles.
//  - Disabled voice (voice_en[k]=0):
//    - phase[k] held at 0;
//    - slot still occupies its cycle; voice_valid still pulses;
//    - voice_sample forced to 0, and the voice contributes 0 to the mix.
//  - ftw and voice_en are sampled per voice at that voice's issue edge.
//  - sample_tick while busy is ignored (no restart, phases untouched) and raises overrun for 1 cycle.
//  - A tick on the same edge busy falls is also an overrun.
//  - busy high from E0 through the edge where the final output of the sweep is registered
//    (mix_valid if MIX_EN, else the last voice_valid).
//  - Sign/width: samples sign-extended to 16+IDX_W before summing; no saturation needed (sum cannot overflow).
// CONFIGURATION
//  SINE_SCHED_MIX_EN defined:
//   - accumulator clears at E0 and adds each valid sample;
//   - mix_out registered at E0+NUM_VOICES+2 with mix_valid pulsing for one cycle;
//   - mix_out holds until the next sweep.
//  SINE_SCHED_MIX_EN undefined:
//   - no accumulator; mix_out tied 0, mix_valid tied 0;
//   - busy drops after the last voice_valid edge (E0+NUM_VOICES+1).
// TESTING (NUM_VOICES=4, PHASE_W=24, bench models ROM as 1-edge registered table)
//  1 Reset: hold reset_n=0, toggle inputs -> every output 0; release, no tick -> outputs stay 0.
//  2 voice_en=4'b0001, ftw0=24'h400000, 5 ticks -> rom_addr for voice 0 is 00,40,80,C0,00 (wrap).
//    voice 0 samples are 16'hFFFF, 16'h7FFE, 16'hFFFF, 16'h8000, 16'hFFFF.
//    Voices 1-3 output 0 each sweep.
//  3 Timing: tick at E0 -> voice_valid in cycles after E0+2..E0+5 with idx 0,1,2,3.
//    MIX_EN: mix_valid after E0+6, busy low after E0+6. Without MIX_EN: busy low after E0+5.
//  4 MIX_EN, voice_en=4'b0011, ftw0=ftw1=24'h400000:
//    - sweep 1: mix_out = 18'h3FFFE (-2);
//    - sweep 2: mix_out = 18'h0FFFC.
//  5 Overrun: second tick 2 cycles after E0 -> overrun pulses 1 cycle, exactly 4 voice_valid pulses.
//    Phases advance once, not twice.
//  6 Reset mid-sweep: assert reset_n=0 at E0+3 -> no further valid pulses, phases 0.
//    Next tick reads address 00 for all voices.

Source files
------------

// File: rtl/sine_voice_scheduler.sv
// Round-robin sharing of one 256x16 synchronous sine ROM among NUM_VOICES DDS voices.
// Define SINE_SCHED_MIX_EN to build the per-sweep signed mix accumulator (mix_out/mix_valid).
module sine_voice_scheduler #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned PHASE_W    = 24,
    parameter int unsigned IDX_W      = 2
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          sample_tick,
    input  logic [NUM_VOICES*PHASE_W-1:0] ftw,
    input  logic [NUM_VOICES-1:0]         voice_en,
    output logic [7:0]                    rom_addr,
    input  logic [15:0]                   rom_data,
    output logic [15:0]                   voice_sample,
    output logic [IDX_W-1:0]              voice_idx,
    output logic                          voice_valid,
    output logic [16+IDX_W-1:0]           mix_out,
    output logic                          mix_valid,
    output logic                          busy,
    output logic                          overrun
);
    localparam int unsigned MIX_W = 16 + IDX_W;
    localparam int unsigned LAST  = NUM_VOICES - 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    state_t state;

    logic [PHASE_W-1:0] phase [NUM_VOICES];
    logic [IDX_W-1:0]   issue_idx;

    // Tag pipeline: stage 1 aligns with rom_addr, stage 2 with the ROM's output register
    logic             p1_valid, p1_en, p1_last;
    logic [IDX_W-1:0] p1_idx;
    logic             p2_valid, p2_en, p2_last;
    logic [IDX_W-1:0] p2_idx;

    logic               issue_c;
    logic [IDX_W-1:0]   sel_c;
    logic [PHASE_W-1:0] sel_phase_c;
    logic [PHASE_W-1:0] sel_ftw_c;
    logic               sel_en_c;
    logic               sel_last_c;
    logic [15:0]        sample_c;
    logic               done_c;

`ifdef SINE_SCHED_MIX_EN
    logic [MIX_W-1:0] acc;
    logic             out_last;
`endif

    // Voice selected for issue this cycle and the sample derived from the ROM word
    always_comb begin
        issue_c     = (state == ISSUE) || ((state == IDLE) && sample_tick);
        sel_c       = (state == ISSUE) ? issue_idx : '0;
        sel_phase_c = phase[sel_c];
        sel_ftw_c   = ftw[32'(sel_c)*PHASE_W +: PHASE_W];
        sel_en_c    = voice_en[sel_c];
        sel_last_c  = (sel_c == IDX_W'(LAST));
        sample_c    = p2_en ? (rom_data ^ 16'h8000) : 16'h0000;
`ifdef SINE_SCHED_MIX_EN
        done_c      = out_last;
`else
        done_c      = p2_valid && p2_last;
`endif
    end

    // Phase accumulators; a disabled voice is parked at phase 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_VOICES; k++) begin
                phase[k] <= '0;
            end
        end else if (issue_c) begin
            phase[sel_c] <= sel_en_c ? (sel_phase_c + sel_ftw_c) : '0;
        end
    end

    // Sweep sequencer, ROM address issue, sample delivery and mixing
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            issue_idx    <= '0;
            rom_addr     <= '0;
            p1_valid     <= 1'b0;
            p1_en        <= 1'b0;
            p1_last      <= 1'b0;
            p1_idx       <= '0;
            p2_valid     <= 1'b0;
            p2_en        <= 1'b0;
            p2_last      <= 1'b0;
            p2_idx       <= '0;
            voice_sample <= '0;
            voice_idx    <= '0;
            voice_valid  <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
`ifdef SINE_SCHED_MIX_EN
            acc          <= '0;
            out_last     <= 1'b0;
            mix_out      <= '0;
            mix_valid    <= 1'b0;
`endif
        end else begin
            voice_valid <= 1'b0;
            overrun     <= 1'b0;
            p1_valid    <= 1'b0;
            p2_valid    <= p1_valid;
            p2_en       <= p1_en;
            p2_last     <= p1_last;
            p2_idx      <= p1_idx;
`ifdef SINE_SCHED_MIX_EN
            mix_valid   <= 1'b0;
            out_last    <= 1'b0;
`endif
            if (issue_c) begin
                rom_addr  <= sel_phase_c[PHASE_W-1 -: 8];
                issue_idx <= sel_c + IDX_W'(1);
                p1_valid  <= 1'b1;
                p1_en     <= sel_en_c;
                p1_last   <= sel_last_c;
                p1_idx    <= sel_c;
            end
            if (p2_valid) begin
                voice_valid  <= 1'b1;
                voice_idx    <= p2_idx;
                voice_sample <= sample_c;
`ifdef SINE_SCHED_MIX_EN
                acc      <= acc + {{IDX_W{sample_c[15]}}, sample_c};
                out_last <= p2_last;
`endif
            end
            case (state)
                IDLE: begin
                    if (sample_tick) begin
                        busy  <= 1'b1;
                        state <= sel_last_c ? DRAIN : ISSUE;
`ifdef SINE_SCHED_MIX_EN
                        acc   <= '0;
`endif
                    end
                end
                ISSUE: begin
                    overrun <= sample_tick;
                    if (sel_last_c) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    overrun <= sample_tick;
                    if (done_c) begin
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef SINE_SCHED_MIX_EN
                        mix_out   <= acc;
                        mix_valid <= 1'b1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SINE_SCHED_MIX_EN
    assign mix_out   = MIX_W'(0);
    assign mix_valid = 1'b0;
`endif

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Bench for sine_voice_scheduler: sweep-level reference model plus a registered sine ROM.
// Honours SINE_SCHED_MIX_EN the same way as the design.
`timescale 1ns/1ps
module tb_sine_voice_scheduler;
    localparam int NV = 4;
`ifdef SINE_SCHED_MIX_EN
    localparam bit MIX = 1'b1;
`else
    localparam bit MIX = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_tick = 1'b0;
    logic [95:0] ftw = '0;
    logic [3:0]  voice_en = '0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic [15:0] voice_sample;
    logic [1:0]  voice_idx;
    logic        voice_valid;
    logic [17:0] mix_out;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    logic [15:0] rom [256];
    logic [23:0] mphase [NV];
    logic [17:0] prev_mix = '0;
    int          n_assert = 0;
    int          n_fail = 0;

    sine_voice_scheduler #(.NUM_VOICES(4), .PHASE_W(24), .IDX_W(2)) dut (
        .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick), .ftw(ftw),
        .voice_en(voice_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .voice_sample(voice_sample), .voice_idx(voice_idx), .voice_valid(voice_valid),
        .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clock = ~clock;

    // Synchronous ROM with one edge of latency
    always @(posedge clock) rom_data <= rom[rom_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'(0));
        chk({tag, "_voice_sample"}, 32'(voice_sample), 32'(0));
        chk({tag, "_voice_idx"}, 32'(voice_idx), 32'(0));
        chk({tag, "_voice_valid"}, 32'(voice_valid), 32'(0));
        chk({tag, "_mix_out"}, 32'(mix_out), 32'(0));
        chk({tag, "_mix_valid"}, 32'(mix_valid), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_overrun"}, 32'(overrun), 32'(0));
    endtask

    task automatic model_reset();
        for (int k = 0; k < NV; k++) mphase[k] = '0;
        prev_mix = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        chk_zero("rst_pulse");
        reset_n = 1'b1;
        step();
        model_reset();
    endtask

    // One full sweep; a second tick lands on edge E0+ovr_c when ovr_c != 0
    task automatic sweep(input int ovr_c, output logic [15:0] s0, output logic [17:0] mix_obs);
        logic [7:0]  ea [NV];
        logic [15:0] es [NV];
        logic [17:0] emix;
        int          sum;
        int          fin;
        bit          vexp;
        fin = MIX ? NV + 2 : NV + 1;
        sum = 0;
        s0 = '0;
        mix_obs = '0;
        for (int k = 0; k < NV; k++) begin
            ea[k] = mphase[k][23:16];
            es[k] = voice_en[k] ? (rom[ea[k]] ^ 16'h8000) : 16'h0000;
            sum += int'($signed(es[k]));
            mphase[k] = voice_en[k] ? mphase[k] + ftw[k*24 +: 24] : 24'h0;
        end
        emix = 18'(sum);
        sample_tick = 1'b1;
        step();
        for (int c = 0; c <= fin + 1; c++) begin
            sample_tick = (ovr_c != 0) && (c + 1 == ovr_c);
            if (c < NV) chk($sformatf("rom_addr_v%0d", c), 32'(rom_addr), 32'(ea[c]));
            vexp = (c >= 2) && (c <= NV + 1);
            chk($sformatf("voice_valid_c%0d", c), 32'(voice_valid), 32'(vexp));
            if (vexp) begin
                chk($sformatf("voice_idx_c%0d", c), 32'(voice_idx), 32'(c - 2));
                chk($sformatf("voice_sample_v%0d", c - 2), 32'(voice_sample), 32'(es[c - 2]));
                if (c == 2) s0 = voice_sample;
            end
            chk($sformatf("busy_c%0d", c), 32'(busy), 32'(c < fin));
            chk($sformatf("overrun_c%0d", c), 32'(overrun), 32'((ovr_c != 0) && (c == ovr_c)));
            chk($sformatf("mix_valid_c%0d", c), 32'(mix_valid), 32'(MIX && (c == NV + 2)));
            chk($sformatf("mix_out_c%0d", c), 32'(mix_out),
                32'((MIX && (c >= NV + 2)) ? emix : prev_mix));
            if (c == fin) mix_obs = mix_out;
            step();
        end
        prev_mix = MIX ? emix : 18'h0;
    endtask

    initial begin
        logic [15:0] s0;
        logic [17:0] mobs;
        logic [15:0] exp_s0 [5];
        int          fin_c;
        exp_s0 = '{16'hFFFF, 16'h7FFE, 16'hFFFF, 16'h8000, 16'hFFFF};
        fin_c = MIX ? NV + 2 : NV + 1;
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'($rtoi($floor(32767.0 + 32767.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0) + 0.5)));
        end
        model_reset();

        // Reset held: inputs toggling, outputs stay zero
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ftw = {32'($urandom), 32'($urandom), 32'($urandom)};
            voice_en = 4'($urandom);
            sample_tick = 1'($urandom);
            step();
            chk_zero("reset_hold");
        end
        sample_tick = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_zero("post_reset_idle");
        end

        // Single voice, quarter-turn step: address walks 00,40,80,C0,00
        voice_en = 4'b0001;
        ftw = {24'($urandom), 24'($urandom), 24'($urandom), 24'h400000};
        for (int i = 0; i < 5; i++) begin
            sweep(0, s0, mobs);
            chk($sformatf("single_voice_s0_%0d", i), 32'(s0), 32'(exp_s0[i]));
            step();
        end

        // Two voices mixed
        do_reset();
        voice_en = 4'b0011;
        ftw = {24'($urandom), 24'($urandom), 24'h400000, 24'h400000};
        sweep(0, s0, mobs);
`ifdef SINE_SCHED_MIX_EN
        chk("mix_sweep1", 32'(mobs), 32'(18'h3FFFE));
`endif
        sweep(0, s0, mobs);
`ifdef SINE_SCHED_MIX_EN
        chk("mix_sweep2", 32'(mobs), 32'(18'h0FFFC));
`endif

        // Overrun mid-sweep and on the edge busy falls; phases advance once
        voice_en = 4'hF;
        ftw = {32'($urandom), 32'($urandom), 32'($urandom)};
        sweep(2, s0, mobs);
        sweep(0, s0, mobs);
        sweep(fin_c, s0, mobs);
        sweep(0, s0, mobs);

        // Randomized sweeps with idle gaps
        for (int i = 0; i < 20; i++) begin
            ftw = {32'($urandom), 32'($urandom), 32'($urandom)};
            voice_en = 4'($urandom);
            sweep(0, s0, mobs);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
        end

        // Reset in the middle of a sweep
        voice_en = 4'hF;
        ftw = {32'($urandom), 32'($urandom), 32'($urandom)};
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        step();
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk_zero("mid_sweep_reset");
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("reset_no_valid_%0d", i), 32'(voice_valid), 32'(0));
            chk($sformatf("reset_no_busy_%0d", i), 32'(busy), 32'(0));
        end
        reset_n = 1'b1;
        step();
        model_reset();
        ftw = {24'h123456, 24'h654321, 24'h0ABCDE, 24'h400000};
        sweep(0, s0, mobs);
        sweep(0, s0, mobs);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
